// File: rtl/keypad_scanner_pkg.sv
// Shared types, key legend map and snapshot classifier for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic {IDLE, PRESSED} kp_state_t;

  typedef enum logic [1:0] {SNAP_NONE, SNAP_SINGLE, SNAP_MULTI} snap_kind_t;

  localparam logic [3:0] KEYMAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  typedef struct packed {
    snap_kind_t kind;
    logic [1:0] row;
    logic [1:0] col;
  } snap_info_t;

  // Snapshot bit c*NUM_ROWS+r is set when row r read low while column c was driven.
  function automatic snap_info_t classify(input logic [NUM_ROWS*NUM_COLS-1:0] snap);
    snap_info_t  info;
    int unsigned hits;
    info.kind = SNAP_NONE;
    info.row  = '0;
    info.col  = '0;
    hits      = 0;
    for (int unsigned i = 0; i < NUM_ROWS*NUM_COLS; i++) begin
      if (snap[i]) begin
        hits++;
        info.row = 2'(i % NUM_ROWS);
        info.col = 2'(i / NUM_ROWS);
      end
    end
    if (hits == 1)
      info.kind = SNAP_SINGLE;
    else if (hits > 1)
      info.kind = SNAP_MULTI;
    return info;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus decoded key outputs; master is the scanner, slave the consumer.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row;
  logic [NUM_COLS-1:0] col;
  logic [3:0]          key_code;
  logic                key_valid;
  logic                key_held;

  modport master (input row, output col, output key_code, output key_valid, output key_held);
  modport slave  (output row, input col, input key_code, input key_valid, input key_held);

endinterface

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to idle-high.
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with snapshot debounce and ghost rejection.
// Optional auto-repeat strobes are enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS     = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  , parameter int unsigned REPEAT_SCANS = 50
`endif
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kif
);

  localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned NK = NUM_ROWS * NUM_COLS;

  logic [NUM_ROWS-1:0]    row_s;
  logic [TW-1:0]          tick;
  logic [1:0]             col_idx;
  logic [NUM_COLS-1:0]    col_r;
  logic                   col_last;
  logic                   scan_end;
  logic [NK-NUM_ROWS-1:0] snap_acc;
  logic [NK-1:0]          snap_full;
  logic [NK-1:0]          prev_snap;
  snap_info_t             info;
  logic [DW-1:0]          deb_cnt;
  logic [DW-1:0]          deb_next;
  logic                   deb_done;
  kp_state_t              state;
  kp_state_t              state_next;
  logic                   accept;
  logic                   rep_fire;
  logic [3:0]             key_code_r;
  logic                   key_valid_r;

  sync2 #(.WIDTH(NUM_ROWS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (kif.row),
    .q     (row_s)
  );

  assign col_last = (tick == TW'(SCAN_TICKS - 1));
  assign scan_end = col_last && (col_idx == 2'(NUM_COLS - 1));

  // The last column is taken straight from the synchronizer so the full
  // snapshot is available on the very cycle that column is sampled.
  assign snap_full = {~row_s, snap_acc};
  assign info      = classify(snap_full);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick     <= '0;
      col_idx  <= '0;
      col_r    <= 4'b1110;
      snap_acc <= '0;
    end else if (col_last) begin
      tick    <= '0;
      col_idx <= col_idx + 2'd1;
      col_r   <= {col_r[NUM_COLS-2:0], col_r[NUM_COLS-1]};
      for (int unsigned c = 0; c < NUM_COLS - 1; c++) begin
        if (col_idx == 2'(c))
          snap_acc[c*NUM_ROWS +: NUM_ROWS] <= ~row_s;
      end
    end else begin
      tick <= tick + TW'(1);
    end
  end

  always_comb begin
    deb_next = DW'(1);
    if (snap_full == prev_snap)
      deb_next = (deb_cnt == DW'(DEBOUNCE_SCANS)) ? deb_cnt : deb_cnt + DW'(1);
    deb_done = (deb_next == DW'(DEBOUNCE_SCANS));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_snap <= '0;
      deb_cnt   <= '0;
    end else if (scan_end) begin
      prev_snap <= snap_full;
      deb_cnt   <= deb_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    if (scan_end && deb_done) begin
      unique case (state)
        IDLE: begin
          if (info.kind == SNAP_SINGLE) begin
            state_next = PRESSED;
            accept     = 1'b1;
          end
        end
        PRESSED: begin
          if (info.kind == SNAP_NONE)
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_SCANS + 1);

  logic [RW-1:0] rep_cnt;

  assign rep_fire = scan_end && (state == PRESSED) && (state_next == PRESSED)
                    && (rep_cnt == RW'(REPEAT_SCANS - 1));

  always_ff @(posedge clk) begin
    if (!reset || state_next != PRESSED || accept)
      rep_cnt <= '0;
    else if (scan_end)
      rep_cnt <= rep_fire ? '0 : rep_cnt + RW'(1);
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_code_r  <= '0;
      key_valid_r <= 1'b0;
    end else begin
      key_valid_r <= accept | rep_fire;
      if (accept)
        key_code_r <= KEYMAP[info.row][info.col];
    end
  end

  assign kif.col       = col_r;
  assign kif.key_code  = key_code_r;
  assign kif.key_valid = key_valid_r;
  assign kif.key_held  = (state == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic clk;
  logic reset;
  logic [3:0] pk [4][4];
  logic [3:0] row_m;

  int unsigned pass_cnt;
  int unsigned total_cnt;
  int cyc;
  int strobe_cnt;
  int last_strobe_cyc;
  int prev_strobe_cyc;
  logic [3:0] last_code;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_TICKS     (4),
    .DEBOUNCE_SCANS (3)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_SCANS (2)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (kif.key_valid) begin
      strobe_cnt++;
      last_code       = kif.key_code;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
    end
  end

  // Row r is pulled low whenever a pressed key in row r sits on the driven column.
  always_comb begin
    row_m = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.col[c] && pk[r][c][0]) row_m[r] = 1'b0;
  end
  assign kif.row = row_m;

  task automatic clear_keys();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pk[r][c] = 4'd0;
  endtask

  task automatic wait_release(input string name);
    for (int i = 0; i < 67 && kif.key_held; i++) @(negedge clk);
    total_cnt++;
    if (kif.key_held !== 1'b0) $display("FAIL %s_release key_held=%b exp 0", name, kif.key_held);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    reset = 1'b0;
    clear_keys();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (kif.col !== 4'b1110) $display("FAIL reset_col got %b exp 1110", kif.col);
    else pass_cnt++;
    total_cnt++;
    if (kif.key_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", kif.key_valid);
    else pass_cnt++;
    total_cnt++;
    if (kif.key_held !== 1'b0) $display("FAIL reset_held got %b exp 0", kif.key_held);
    else pass_cnt++;
    total_cnt++;
    if (kif.key_code !== 4'h0) $display("FAIL reset_code got %h exp 0", kif.key_code);
    else pass_cnt++;
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp = ~(4'b0001 << ((k / 4) % 4));
      total_cnt++;
      if (kif.col !== exp) $display("FAIL scan_col k=%0d got %b exp %b", k, kif.col, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_key();
    int s0, t0;
    s0 = strobe_cnt;
    t0 = cyc;
    pk[1][2] = 4'd1;
    repeat (80) @(negedge clk);
    total_cnt++;
    if (strobe_cnt - s0 !== 1) $display("FAIL single_count got %0d exp 1", strobe_cnt - s0);
    else pass_cnt++;
    total_cnt++;
    if (last_code !== 4'h6) $display("FAIL single_code got %h exp 6", last_code);
    else pass_cnt++;
    total_cnt++;
    if (last_strobe_cyc - t0 > 67) $display("FAIL single_latency got %0d exp <=67", last_strobe_cyc - t0);
    else pass_cnt++;
    total_cnt++;
    if (kif.key_held !== 1'b1) $display("FAIL single_held got %b exp 1", kif.key_held);
    else pass_cnt++;
    pk[1][2] = 4'd0;
    wait_release("single");
    repeat (20) @(negedge clk);
    total_cnt++;
    if (strobe_cnt - s0 !== 1) $display("FAIL single_no_release_strobe got %0d exp 1", strobe_cnt - s0);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int s0, t_stable;
    s0 = strobe_cnt;
    for (int i = 0; i < 8; i++) begin
      pk[3][0] = (i % 2 == 0) ? 4'd1 : 4'd0;
      repeat (5) @(negedge clk);
    end
    pk[3][0] = 4'd1;
    t_stable = cyc;
    repeat (80) @(negedge clk);
    total_cnt++;
    if (strobe_cnt - s0 !== 1) $display("FAIL bounce_count got %0d exp 1", strobe_cnt - s0);
    else pass_cnt++;
    total_cnt++;
    if (last_code !== 4'h0) $display("FAIL bounce_code got %h exp 0", last_code);
    else pass_cnt++;
    total_cnt++;
    if (last_strobe_cyc <= t_stable) $display("FAIL bounce_timing strobe at %0d exp after %0d", last_strobe_cyc, t_stable);
    else pass_cnt++;
    pk[3][0] = 4'd0;
    wait_release("bounce");
  endtask

  task automatic test_ghost();
    int s0;
    s0 = strobe_cnt;
    pk[0][0] = 4'd1;
    pk[1][1] = 4'd1;
    repeat (100) @(negedge clk);
    total_cnt++;
    if (strobe_cnt - s0 !== 0) $display("FAIL ghost_count got %0d exp 0", strobe_cnt - s0);
    else pass_cnt++;
    total_cnt++;
    if (kif.key_held !== 1'b0) $display("FAIL ghost_held got %b exp 0", kif.key_held);
    else pass_cnt++;
    pk[1][1] = 4'd0;
    repeat (80) @(negedge clk);
    total_cnt++;
    if (strobe_cnt - s0 !== 1) $display("FAIL ghost_single_count got %0d exp 1", strobe_cnt - s0);
    else pass_cnt++;
    total_cnt++;
    if (last_code !== 4'h1) $display("FAIL ghost_single_code got %h exp 1", last_code);
    else pass_cnt++;
    pk[0][0] = 4'd0;
    wait_release("ghost");
  endtask

  task automatic test_reset_midpress();
    int s0;
    pk[2][1] = 4'd1;
    for (int i = 0; i < 80 && !kif.key_held; i++) @(negedge clk);
    total_cnt++;
    if (kif.key_held !== 1'b1) $display("FAIL midreset_pre_held got %b exp 1", kif.key_held);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({kif.col, kif.key_code, kif.key_valid, kif.key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0})
      $display("FAIL midreset_outputs got col=%b code=%h valid=%b held=%b exp 1110/0/0/0",
               kif.col, kif.key_code, kif.key_valid, kif.key_held);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    s0 = strobe_cnt;
    reset = 1'b1;
    for (int i = 0; i < 67 && strobe_cnt == s0; i++) @(negedge clk);
    total_cnt++;
    if (strobe_cnt - s0 !== 1) $display("FAIL midreset_restrobe got %0d exp 1", strobe_cnt - s0);
    else pass_cnt++;
    total_cnt++;
    if (last_code !== 4'h8) $display("FAIL midreset_code got %h exp 8", last_code);
    else pass_cnt++;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (strobe_cnt - s0 !== 1) $display("FAIL midreset_single got %0d exp 1", strobe_cnt - s0);
    else pass_cnt++;
    pk[2][1] = 4'd0;
    wait_release("midreset");
  endtask

  task automatic test_repeat();
    int s0;
    s0 = strobe_cnt;
    pk[3][3] = 4'd1;
    repeat (120) @(negedge clk);
    total_cnt++;
    if (last_code !== 4'hD) $display("FAIL repeat_code got %h exp D", last_code);
    else pass_cnt++;
`ifdef KEYPAD_REPEAT_EN
    total_cnt++;
    if (strobe_cnt - s0 < 2) $display("FAIL repeat_count got %0d exp >=2", strobe_cnt - s0);
    else pass_cnt++;
    total_cnt++;
    if (last_strobe_cyc - prev_strobe_cyc !== 32)
      $display("FAIL repeat_interval got %0d exp 32", last_strobe_cyc - prev_strobe_cyc);
    else pass_cnt++;
`else
    total_cnt++;
    if (strobe_cnt - s0 !== 1) $display("FAIL repeat_count got %0d exp 1", strobe_cnt - s0);
    else pass_cnt++;
`endif
    pk[3][3] = 4'd0;
    wait_release("repeat");
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    cyc             = 0;
    strobe_cnt      = 0;
    last_strobe_cyc = 0;
    prev_strobe_cyc = 0;
    last_code       = 4'h0;
    reset           = 1'b0;
    clear_keys();
    test_reset();
    test_single_key();
    test_bounce();
    test_ghost();
    test_reset_midpress();
    test_repeat();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
